// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU plus iterative multiplier behind one registered result slot.
// Optional `EXEC_FLUSH_EN adds exec_i_flush to drop the slot and abort a multiply.
module exec_stage #(
    parameter int unsigned XLEN             = 64,
    parameter int unsigned MUL_BITS_PER_CYC = 1
) (
    input  logic            clk,
    input  logic            rst,
`ifdef EXEC_FLUSH_EN
    input  logic            exec_i_flush,
`endif
    input  logic            regE_i_valid,
    output logic            exec_o_ready,
    input  logic [XLEN-1:0] regE_i_regdata1,
    input  logic [XLEN-1:0] regE_i_regdata2,
    input  logic [XLEN-1:0] regE_i_imm,
    input  logic [XLEN-1:0] regE_i_pc,
    input  logic [9:0]      regE_i_alu_info,
    input  logic [1:0]      regE_i_opcode_info,
    input  logic            regE_i_mul_en,
    input  logic [4:0]      regE_i_rd,
    input  logic            regE_i_reg_wen,
    output logic            exec_o_valid,
    input  logic            exec_i_ready,
    output logic [XLEN-1:0] exec_o_result,
    output logic [XLEN-1:0] exec_o_pc,
    output logic [4:0]      exec_o_rd,
    output logic            exec_o_reg_wen,
    output logic            exec_o_busy
);
    localparam int unsigned MUL_ITERS = XLEN / MUL_BITS_PER_CYC;
    localparam int unsigned CNT_W     = $clog2(MUL_ITERS + 1);
    localparam int unsigned SHW       = $clog2(XLEN);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  mul_cnt;
    logic [XLEN-1:0]   mul_a;
    logic [XLEN-1:0]   mul_b;
    logic [XLEN-1:0]   mul_acc;
    logic [XLEN-1:0]   mul_pc;
    logic [4:0]        mul_rd;
    logic              mul_wen;

    logic              flush;
    logic              slot_free;
    logic              accept;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   mul_partial;
    logic [XLEN-1:0]   acc_next;

`ifdef EXEC_FLUSH_EN
    assign flush = exec_i_flush;
`else
    assign flush = 1'b0;
`endif

    assign slot_free    = !exec_o_valid || exec_i_ready;
    assign exec_o_ready = (state == ST_IDLE) && slot_free && !flush;
    assign accept       = regE_i_valid && exec_o_ready;
    assign exec_o_busy  = (state != ST_IDLE);

    always_comb begin
        op_a  = regE_i_opcode_info[1] ? regE_i_pc  : regE_i_regdata1;
        op_b  = regE_i_opcode_info[0] ? regE_i_imm : regE_i_regdata2;
        shamt = op_b[SHW-1:0];
        // Lowest set alu_info bit takes priority; no bit set passes B through.
        if (regE_i_alu_info[0])
            alu_result = op_a + op_b;
        else if (regE_i_alu_info[1])
            alu_result = op_a - op_b;
        else if (regE_i_alu_info[2])
            alu_result = op_a & op_b;
        else if (regE_i_alu_info[3])
            alu_result = op_a | op_b;
        else if (regE_i_alu_info[4])
            alu_result = op_a ^ op_b;
        else if (regE_i_alu_info[5])
            alu_result = op_a << shamt;
        else if (regE_i_alu_info[6])
            alu_result = op_a >> shamt;
        else if (regE_i_alu_info[7])
            alu_result = $signed(op_a) >>> shamt;
        else if (regE_i_alu_info[8])
            alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        else if (regE_i_alu_info[9])
            alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
        else
            alu_result = op_b;
    end

    always_comb begin
        mul_partial = '0;
        for (int unsigned i = 0; i < MUL_BITS_PER_CYC; i++) begin
            if (mul_a[i])
                mul_partial = mul_partial + (mul_b << i);
        end
        acc_next = mul_acc + mul_partial;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            mul_cnt        <= '0;
            mul_a          <= '0;
            mul_b          <= '0;
            mul_acc        <= '0;
            mul_pc         <= '0;
            mul_rd         <= '0;
            mul_wen        <= 1'b0;
            exec_o_valid   <= 1'b0;
            exec_o_result  <= '0;
            exec_o_pc      <= '0;
            exec_o_rd      <= '0;
            exec_o_reg_wen <= 1'b0;
        end else if (flush) begin
            exec_o_valid <= 1'b0;
            state        <= ST_IDLE;
            mul_cnt      <= '0;
        end else begin
            // Drain by default; any load below overrides it so back-to-back keeps valid high.
            if (exec_o_valid && exec_i_ready)
                exec_o_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (regE_i_mul_en) begin
                            mul_a   <= op_a;
                            mul_b   <= op_b;
                            mul_acc <= '0;
                            mul_pc  <= regE_i_pc;
                            mul_rd  <= regE_i_rd;
                            mul_wen <= regE_i_reg_wen;
                            mul_cnt <= CNT_W'(MUL_ITERS);
                            state   <= ST_MUL;
                        end else begin
                            exec_o_result  <= alu_result;
                            exec_o_pc      <= regE_i_pc;
                            exec_o_rd      <= regE_i_rd;
                            exec_o_reg_wen <= regE_i_reg_wen;
                            exec_o_valid   <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    mul_a   <= mul_a >> MUL_BITS_PER_CYC;
                    mul_b   <= mul_b << MUL_BITS_PER_CYC;
                    mul_cnt <= mul_cnt - CNT_W'(1);
                    if (mul_cnt == CNT_W'(1)) begin
                        if (slot_free) begin
                            exec_o_result  <= acc_next;
                            exec_o_pc      <= mul_pc;
                            exec_o_rd      <= mul_rd;
                            exec_o_reg_wen <= mul_wen;
                            exec_o_valid   <= 1'b1;
                            state          <= ST_IDLE;
                        end else begin
                            mul_acc <= acc_next;
                            state   <= ST_DONE;
                        end
                    end else begin
                        mul_acc <= acc_next;
                    end
                end
                ST_DONE: begin
                    if (slot_free) begin
                        exec_o_result  <= mul_acc;
                        exec_o_pc      <= mul_pc;
                        exec_o_rd      <= mul_rd;
                        exec_o_reg_wen <= mul_wen;
                        exec_o_valid   <= 1'b1;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed vectors plus randomized traffic against a
// cycle-level scoreboard model of the result slot and multiply latency.
module tb_exec_stage;
    typedef struct packed {
        logic        vld;
        logic [63:0] r1;
        logic [63:0] r2;
        logic [63:0] imm;
        logic [63:0] pc;
        logic [9:0]  info;
        logic [1:0]  opc;
        logic        mul;
        logic [4:0]  rd;
        logic        wen;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_in;
    logic        regE_i_valid;
    logic        exec_o_ready;
    logic [63:0] regE_i_regdata1, regE_i_regdata2, regE_i_imm, regE_i_pc;
    logic [9:0]  regE_i_alu_info;
    logic [1:0]  regE_i_opcode_info;
    logic        regE_i_mul_en;
    logic [4:0]  regE_i_rd;
    logic        regE_i_reg_wen;
    logic        exec_o_valid;
    logic        exec_i_ready;
    logic [63:0] exec_o_result, exec_o_pc;
    logic [4:0]  exec_o_rd;
    logic        exec_o_reg_wen;
    logic        exec_o_busy;

    exec_stage #(.XLEN(64), .MUL_BITS_PER_CYC(1)) dut (
        .clk(clk), .rst(rst),
`ifdef EXEC_FLUSH_EN
        .exec_i_flush(flush_in),
`endif
        .regE_i_valid(regE_i_valid), .exec_o_ready(exec_o_ready),
        .regE_i_regdata1(regE_i_regdata1), .regE_i_regdata2(regE_i_regdata2),
        .regE_i_imm(regE_i_imm), .regE_i_pc(regE_i_pc),
        .regE_i_alu_info(regE_i_alu_info), .regE_i_opcode_info(regE_i_opcode_info),
        .regE_i_mul_en(regE_i_mul_en), .regE_i_rd(regE_i_rd), .regE_i_reg_wen(regE_i_reg_wen),
        .exec_o_valid(exec_o_valid), .exec_i_ready(exec_i_ready),
        .exec_o_result(exec_o_result), .exec_o_pc(exec_o_pc), .exec_o_rd(exec_o_rd),
        .exec_o_reg_wen(exec_o_reg_wen), .exec_o_busy(exec_o_busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected slot contents plus one pending multiply with its due edge.
    logic        m_valid;
    logic [63:0] m_result, m_pc;
    logic [4:0]  m_rd;
    logic        m_wen;
    bit          m_pending;
    int          m_due;
    int          ecount;
    logic [63:0] p_result, p_pc;
    logic [4:0]  p_rd;
    logic        p_wen;

    function automatic logic [63:0] ref_alu(input logic [9:0] info, input logic [63:0] a,
                                            input logic [63:0] b);
        int sel = -1;
        for (int i = 9; i >= 0; i--) if (info[i]) sel = i;
        case (sel)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << b[5:0];
            6: return a >> b[5:0];
            7: return $signed(a) >>> b[5:0];
            8: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            9: return (a < b) ? 64'd1 : 64'd0;
            default: return b;
        endcase
    endfunction

    function automatic instr_t idle_instr();
        instr_t t = '0;
        return t;
    endfunction

    function automatic instr_t mk(input logic [63:0] r1, input logic [63:0] r2,
                                  input logic [63:0] imm, input logic [9:0] info,
                                  input logic [1:0] opc, input logic mul);
        instr_t t;
        t.vld = 1'b1; t.r1 = r1; t.r2 = r2; t.imm = imm; t.pc = 64'h1000 + 64'($urandom_range(0, 255) * 4);
        t.info = info; t.opc = opc; t.mul = mul; t.rd = 5'($urandom); t.wen = 1'($urandom);
        return t;
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0: return 64'h8000_0000_0000_0000;
            1: return '1;
            2: return 64'($urandom_range(0, 70));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_result = '0; m_pc = '0; m_rd = '0; m_wen = 0; m_pending = 0;
    endtask

    // One clock: check outputs, drive inputs, check ready, then advance the model across the edge.
    task automatic step(input instr_t in, input logic rdy);
        logic [63:0] a, b;
        bit m_ready, slot_free;
        @(negedge clk);
        check_eq("valid", exec_o_valid, m_valid);
        check_eq("busy", exec_o_busy, m_pending);
        if (m_valid) begin
            check_eq("result", exec_o_result, m_result);
            check_eq("pc", exec_o_pc, m_pc);
            check_eq("rd", exec_o_rd, m_rd);
            check_eq("reg_wen", exec_o_reg_wen, m_wen);
        end
        regE_i_valid = in.vld; regE_i_regdata1 = in.r1; regE_i_regdata2 = in.r2;
        regE_i_imm = in.imm; regE_i_pc = in.pc; regE_i_alu_info = in.info;
        regE_i_opcode_info = in.opc; regE_i_mul_en = in.mul; regE_i_rd = in.rd;
        regE_i_reg_wen = in.wen; exec_i_ready = rdy;
        #1;
        m_ready = !m_pending && (!m_valid || rdy);
        check_eq("ready", exec_o_ready, m_ready);
        ecount++;
        slot_free = !m_valid || rdy;
        if (m_valid && rdy) m_valid = 0;
        a = in.opc[1] ? in.pc : in.r1;
        b = in.opc[0] ? in.imm : in.r2;
        if (m_pending) begin
            if (ecount >= m_due && slot_free) begin
                m_valid = 1; m_result = p_result; m_pc = p_pc; m_rd = p_rd; m_wen = p_wen;
                m_pending = 0;
            end
        end else if (in.vld && m_ready) begin
            if (in.mul) begin
                m_pending = 1; m_due = ecount + 64;
                p_result = a * b; p_pc = in.pc; p_rd = in.rd; p_wen = in.wen;
            end else begin
                m_valid = 1; m_result = ref_alu(in.info, a, b);
                m_pc = in.pc; m_rd = in.rd; m_wen = in.wen;
            end
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_valid", exec_o_valid, 0);
        check_eq("rst_busy", exec_o_busy, 0);
        check_eq("rst_result", exec_o_result, 0);
        check_eq("rst_pc", exec_o_pc, 0);
        check_eq("rst_rd", exec_o_rd, 0);
        check_eq("rst_wen", exec_o_reg_wen, 0);
        regE_i_valid = 0; exec_i_ready = 1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1 check_eq("ready_after_rst", exec_o_ready, 1);
    endtask

    initial begin
        int first;
        instr_t t;
        rst = 1'b1; flush_in = 1'b0; ecount = 0;
        regE_i_valid = 0; exec_i_ready = 1; regE_i_regdata1 = '0; regE_i_regdata2 = '0;
        regE_i_imm = '0; regE_i_pc = '0; regE_i_alu_info = '0; regE_i_opcode_info = '0;
        regE_i_mul_en = 0; regE_i_rd = '0; regE_i_reg_wen = 0;
        model_reset();
        #12;
        check_eq("reset_valid", exec_o_valid, 0);
        check_eq("reset_result", exec_o_result, 0);
        check_eq("reset_busy", exec_o_busy, 0);
        @(negedge clk) rst = 1'b0;

        // add A=rs1 5, B=imm -3
        step(mk(64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 10'b1, 2'b01, 0), 1'b1);
        after_edge();
        check_eq("add_imm", exec_o_result, 64'd2);
        check_eq("add_valid", exec_o_valid, 1);
        step(mk(64'h8000_0000_0000_0000, 64'd4, 64'd0, 10'b1 << 7, 2'b00, 0), 1'b1);
        after_edge();
        check_eq("sra", exec_o_result, 64'hF800_0000_0000_0000);
        step(mk(64'd1, '1, 64'd0, 10'b1 << 9, 2'b00, 0), 1'b1);
        after_edge();
        check_eq("sltu", exec_o_result, 64'd1);
        step(mk(64'd7, 64'd9, 64'd0, 10'b0, 2'b00, 0), 1'b1);
        step(idle_instr(), 1'b1);

        // multiply latency
        step(mk(64'h1_0000_0001, 64'd3, 64'd0, 10'b0, 2'b00, 1), 1'b1);
        first = -1;
        for (int k = 1; k <= 80; k++) begin
            step(idle_instr(), 1'b1);
            after_edge();
            if (first < 0 && exec_o_valid) first = k;
            if (first < 0 && k < 64) check_eq("mul_busy", exec_o_busy, 1);
        end
        check_eq("mul_latency", 64'(first), 64'd64);

        // stalled slot, then drain with same-cycle accept
        step(mk(64'd100, 64'd1, 64'd0, 10'b10, 2'b00, 0), 1'b0);
        for (int k = 0; k < 10; k++) step(mk(rnd64(), rnd64(), rnd64(), 10'b1, 2'b00, 0), 1'b0);
        check_eq("stall_result", exec_o_result, 64'd99);
        step(mk(64'd20, 64'd22, 64'd0, 10'b1, 2'b00, 0), 1'b1);
        after_edge();
        check_eq("b2b_result", exec_o_result, 64'd42);
        check_eq("b2b_valid", exec_o_valid, 1);
        // multiply finishing into a stalled consumer
        step(mk(64'd6, 64'd7, 64'd0, 10'b0, 2'b00, 1), 1'b1);
        for (int k = 0; k < 75; k++) step(idle_instr(), 1'b0);
        check_eq("mul_held", exec_o_result, 64'd42);
        step(idle_instr(), 1'b1);

        // reset in the middle of a multiply
        step(mk(rnd64(), rnd64(), 64'd0, 10'b0, 2'b00, 1), 1'b1);
        for (int k = 0; k < 20; k++) step(idle_instr(), 1'b1);
        async_reset();

`ifdef EXEC_FLUSH_EN
        step(mk(rnd64(), rnd64(), 64'd0, 10'b0, 2'b00, 1), 1'b1);
        for (int k = 0; k < 19; k++) step(idle_instr(), 1'b1);
        @(negedge clk);
        flush_in = 1'b1; regE_i_valid = 1'b1; regE_i_mul_en = 1'b0;
        #1 check_eq("flush_ready", exec_o_ready, 0);
        after_edge();
        check_eq("flush_busy", exec_o_busy, 0);
        check_eq("flush_valid", exec_o_valid, 0);
        @(negedge clk) flush_in = 1'b0;
        model_reset();
        for (int k = 0; k < 70; k++) step(idle_instr(), 1'b1);
`endif

        for (int n = 0; n < 1500; n++) begin
            logic [9:0] info;
            int s = $urandom_range(0, 11);
            info = (s < 10) ? (10'b1 << s) : (s == 10) ? 10'b0 : 10'($urandom);
            t = mk(rnd64(), rnd64(), rnd64(), info, 2'($urandom), ($urandom_range(0, 15) == 0));
            t.vld = ($urandom_range(0, 3) != 0);
            step(t, ($urandom_range(0, 3) != 0));
        end
        for (int k = 0; k < 80; k++) step(idle_instr(), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
